// File: rtl/mips_lsu_pkg.sv
// Shared types for the load/store port: opcode encodings, store-buffer entry
// layout and the load lane-extraction helper.
package mips_lsu_pkg;

    typedef enum logic [2:0] {
        LW  = 3'd0,
        LB  = 3'd1,
        LBU = 3'd2,
        SW  = 3'd3,
        SB  = 3'd4
    } req_op_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        is_byte;
    } sb_entry_t;

    // Picks the addressed byte for LB/LBU; anything else returns the word.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input req_op_e     op,
                                                 input logic [1:0]  lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        case (op)
            LB:      return {{24{b[7]}}, b};
            LBU:     return {24'h0, b};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/lsu_store_buf.sv
// In-order store FIFO with a parallel word-address compare across all live
// entries, used to stall loads that would read around a pending store.
module lsu_store_buf
    import mips_lsu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  sb_entry_t   push_entry,
    input  logic        pop,
    input  logic [29:0] match_addr,
    output sb_entry_t   head,
    output logic        full,
    output logic        empty,
    output logic        match
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    sb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = entries[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            vld    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // push and pop never target the same slot: both only occur when
            // the buffer is neither empty nor full
            if (do_push) begin
                entries[wr_ptr] <= push_entry;
                vld[wr_ptr]     <= 1'b1;
                wr_ptr          <= bump(wr_ptr);
            end
            if (do_pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (vld[i] && (entries[i].addr[31:2] == match_addr)) match = 1'b1;
    end

endmodule

// File: rtl/lsu_port.sv
// Data-memory port: accepts pipeline loads/stores, buffers stores, arbitrates
// the single memory port (loads first) and returns load/error responses.
module lsu_port
    import mips_lsu_pkg::*;
#(
    parameter int SB_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_tag,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_tag,
    output logic        resp_err,
    output logic        mem_we,
    output logic        mem_sb,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic        sb_empty
);

    req_op_e   op;
    sb_entry_t head, new_entry;
    logic      is_load, is_store, misalign, hazard, sb_full;
    logic      load_go, bad_go, push, drain;

    assign op = req_op_e'(req_op);

    always_comb begin
        is_load  = (op == LW) || (op == LB) || (op == LBU);
        is_store = (op == SW) || (op == SB);
        misalign = ((op == LW) || (op == SW) || (op == SB)) && (req_addr[1:0] != 2'b00);
    end

    // Unknown opcodes are swallowed without a response so they cannot wedge
    // the pipeline.
    assign req_ready = !reset && (misalign
                                  || (is_load && !hazard)
                                  || (is_store && !sb_full)
                                  || (!is_load && !is_store));

    assign load_go = req_valid && req_ready && is_load && !misalign;
    assign bad_go  = req_valid && req_ready && misalign;
    assign push    = req_valid && req_ready && is_store && !misalign;
    assign drain   = !reset && !sb_empty && !load_go;

    assign new_entry = '{addr: req_addr, data: req_wdata, is_byte: (op == SB)};

    lsu_store_buf #(.DEPTH(SB_DEPTH)) u_sb (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (new_entry),
        .pop        (drain),
        .match_addr (req_addr[31:2]),
        .head       (head),
        .full       (sb_full),
        .empty      (sb_empty),
        .match      (hazard)
    );

    always_comb begin
        mem_we = 1'b0;
        mem_sb = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        if (load_go) begin
            mem_a = {req_addr[31:2], 2'b00};
        end else if (drain) begin
            mem_we = 1'b1;
            mem_sb = head.is_byte;
            mem_a  = head.addr;
            mem_wd = head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            resp_tag   <= '0;
        end else begin
            resp_valid <= load_go || bad_go;
            resp_err   <= bad_go;
            resp_tag   <= (load_go || bad_go) ? req_tag : '0;
            resp_data  <= load_go ? lane_extract(mem_rd, op, req_addr[1:0]) : '0;
        end
    end

endmodule

// File: tb/tb_lsu_port.sv
// Directed bench for lsu_port with a behavioural word memory; a second
// SB_DEPTH=1 instance shares the request bus to exercise the full-buffer case.
module tb_lsu_port;
    import mips_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, preload;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_tag;
    logic        req_ready, resp_valid, resp_err, mem_we, mem_sb, sb_empty;
    logic [31:0] resp_data, mem_a, mem_wd, mem_rd;
    logic [4:0]  resp_tag;
    logic        req_ready1, resp_valid1, resp_err1, mem_we1, mem_sb1, sb_empty1;
    logic [31:0] resp_data1, mem_a1, mem_wd1, mem_rd1;
    logic [4:0]  resp_tag1;

    logic [31:0] mem [64];
    logic [31:0] wr_log [$];
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    lsu_port dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_tag(resp_tag),
        .resp_err(resp_err), .mem_we(mem_we), .mem_sb(mem_sb), .mem_a(mem_a),
        .mem_wd(mem_wd), .mem_rd(mem_rd), .sb_empty(sb_empty)
    );

    lsu_port #(.SB_DEPTH(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready1),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .resp_valid(resp_valid1), .resp_data(resp_data1), .resp_tag(resp_tag1),
        .resp_err(resp_err1), .mem_we(mem_we1), .mem_sb(mem_sb1), .mem_a(mem_a1),
        .mem_wd(mem_wd1), .mem_rd(mem_rd1), .sb_empty(sb_empty1)
    );

    assign mem_rd  = mem[mem_a[7:2]];
    assign mem_rd1 = mem[mem_a1[7:2]];

    // Only the main instance writes memory; dut1 is observed at its port.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[16] <= 32'h11223344;
            mem[20] <= 32'h80FF7F01;
            mem[24] <= 32'hAABBCCDD;
        end else if (mem_we) begin
            if (mem_sb) mem[mem_a[7:2]][7:0] <= mem_wd[7:0];
            else        mem[mem_a[7:2]]      <= mem_wd;
            wr_log.push_back(mem_a);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] tag);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_tag = tag;
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0; req_tag = 5'd0;
        #1;
    endtask

    task automatic load_case(input string nm, input logic [2:0] op, input logic [31:0] addr,
                             input logic [4:0] tag, input logic [31:0] exp);
        issue(op, addr, 32'h0, tag);
        chk({nm, "_ready"}, 32'(req_ready), 32'd1);
        chk({nm, "_mem_a"}, mem_a, {addr[31:2], 2'b00});
        idle();
        chk({nm, "_valid"}, 32'(resp_valid), 32'd1);
        chk({nm, "_data"}, resp_data, exp);
        chk({nm, "_tag"}, 32'(resp_tag), 32'(tag));
        chk({nm, "_err"}, 32'(resp_err), 32'd0);
    endtask

    task automatic bad_case(input string nm, input logic [2:0] op, input logic [31:0] addr,
                            input logic [4:0] tag);
        issue(op, addr, 32'hCAFEF00D, tag);
        chk({nm, "_ready"}, 32'(req_ready), 32'd1);
        chk({nm, "_we"}, 32'(mem_we), 32'd0);
        idle();
        chk({nm, "_valid"}, 32'(resp_valid), 32'd1);
        chk({nm, "_err"}, 32'(resp_err), 32'd1);
        chk({nm, "_data"}, resp_data, 32'h0);
        chk({nm, "_tag"}, 32'(resp_tag), 32'(tag));
        chk({nm, "_we2"}, 32'(mem_we), 32'd0);
        chk({nm, "_empty"}, 32'(sb_empty), 32'd1);
    endtask

    initial begin
        preload = 1'b1; reset = 1'b1;
        req_valid = 1'b1; req_op = LW; req_addr = 32'h40; req_wdata = 32'h0; req_tag = 5'd3;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_data", resp_data, 32'h0);
        chk("rst_tag", 32'(resp_tag), 32'd0);
        chk("rst_empty", 32'(sb_empty), 32'd1);
        chk("rst_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        reset = 1'b0; preload = 1'b0; req_valid = 1'b0;

        load_case("lw40", LW, 32'h40, 5'd5, 32'h11223344);
        chk("lw40_pulse", 32'(resp_valid), 32'd1);
        idle();
        chk("lw40_pulse_end", 32'(resp_valid), 32'd0);
        load_case("lb53", LB, 32'h53, 5'd6, 32'hFFFFFF80);
        load_case("lbu53", LBU, 32'h53, 5'd7, 32'h00000080);
        load_case("lb51", LB, 32'h51, 5'd8, 32'h0000007F);
        load_case("lbu52", LBU, 32'h52, 5'd9, 32'h000000FF);
        load_case("lb50", LB, 32'h50, 5'd10, 32'h00000001);

        // store then dependent load: stall through the drain cycle
        issue(SW, 32'h44, 32'hDEADBEEF, 5'd1);
        chk("sw44_ready", 32'(req_ready), 32'd1);
        chk("sw44_we", 32'(mem_we), 32'd0);
        issue(LW, 32'h44, 32'h0, 5'd2);
        chk("haz_ready", 32'(req_ready), 32'd0);
        chk("haz_we", 32'(mem_we), 32'd1);
        chk("haz_a", mem_a, 32'h44);
        chk("haz_wd", mem_wd, 32'hDEADBEEF);
        chk("haz_sb", 32'(mem_sb), 32'd0);
        chk("haz_noresp", 32'(resp_valid), 32'd0);
        chk("haz_empty", 32'(sb_empty), 32'd0);
        @(negedge clk); #1;
        chk("haz_go_ready", 32'(req_ready), 32'd1);
        chk("haz_go_we", 32'(mem_we), 32'd0);
        idle();
        chk("haz_data", resp_data, 32'hDEADBEEF);
        chk("haz_tag", 32'(resp_tag), 32'd2);
        chk("haz_empty2", 32'(sb_empty), 32'd1);

        // ordering, load priority, and full rejection on the depth-1 copy
        wr_log.delete();
        issue(SW, 32'h48, 32'hA0A0A0A0, 5'd0);
        chk("ord_a_ready", 32'(req_ready), 32'd1);
        chk("ord_a_ready1", 32'(req_ready1), 32'd1);
        issue(LW, 32'h40, 32'h0, 5'd9);
        chk("ord_ld_ready", 32'(req_ready), 32'd1);
        chk("ord_ld_prio", 32'(mem_we), 32'd0);
        issue(SW, 32'h4C, 32'hB0B0B0B0, 5'd0);
        chk("ord_ld_data", resp_data, 32'h11223344);
        chk("ord_ld_tag", 32'(resp_tag), 32'd9);
        chk("ord_b_ready", 32'(req_ready), 32'd1);
        chk("ord_b_drain_a", mem_a, 32'h48);
        chk("full_rej", 32'(req_ready1), 32'd0);
        chk("full_drain", 32'(mem_we1), 32'd1);
        issue(SW, 32'h48, 32'hC0C0C0C0, 5'd0);
        chk("ord_c_ready", 32'(req_ready), 32'd1);
        chk("ord_c_drain_b", mem_a, 32'h4C);
        chk("full_after", 32'(req_ready1), 32'd1);
        idle();
        chk("ord_drain_c_we", 32'(mem_we), 32'd1);
        chk("ord_drain_c_wd", mem_wd, 32'hC0C0C0C0);
        idle();
        chk("ord_empty", 32'(sb_empty), 32'd1);
        chk("ord_nwr", 32'(wr_log.size()), 32'd3);
        chk("ord_wr0", wr_log[0], 32'h48);
        chk("ord_wr1", wr_log[1], 32'h4C);
        chk("ord_wr2", wr_log[2], 32'h48);
        chk("ord_mem48", mem[18], 32'hC0C0C0C0);
        chk("ord_mem4c", mem[19], 32'hB0B0B0B0);

        // aligned byte store touches only bits 7:0
        issue(SB, 32'h60, 32'h123456EE, 5'd0);
        chk("sb60_ready", 32'(req_ready), 32'd1);
        idle();
        chk("sb60_we", 32'(mem_we), 32'd1);
        chk("sb60_sb", 32'(mem_sb), 32'd1);
        chk("sb60_a", mem_a, 32'h60);
        idle();
        chk("sb60_mem", mem[24], 32'hAABBCCEE);

        bad_case("sw42", SW, 32'h42, 5'd7);
        bad_case("sb41", SB, 32'h41, 5'd8);
        bad_case("lw46", LW, 32'h46, 5'd11);

        // reset discards a buffered store before it drains
        wr_log.delete();
        issue(SW, 32'h70, 32'h55AA55AA, 5'd0);
        chk("rst2_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0; reset = 1'b1;
        #1;
        chk("rst2_we", 32'(mem_we), 32'd0);
        chk("rst2_ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst2_empty", 32'(sb_empty), 32'd1);
        chk("rst2_we_after", 32'(mem_we), 32'd0);
        idle();
        idle();
        chk("rst2_nwr", 32'(wr_log.size()), 32'd0);
        chk("rst2_mem", mem[28], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
